arqt_mem_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single-port 2048×32 on-chip memory between two masters, e.g. the processor data master (port 0) and a DMA/accelerator master (port 1). It accepts at most one command per cycle and drives the memory's address/byteenable/chipselect/write/writedata/clken pins. It routes the 1-cycle-latency read data back to the issuing port with `readdatavalid`. Fairness comes from round-robin ownership with a bounded hold count.

---
 rtl/arqt_mem_arbiter.sv | 100 ++++++++++
 tb/tb_arqt_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arqt_mem_arbiter.sv
// arqt_mem_arbiter: two-port Avalon-MM arbiter sharing one single-port on-chip RAM.
// Define ARQT_MEMARB_RR_EN for round-robin with a MAX_HOLD bound; otherwise port 0 has fixed priority.
module arqt_mem_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic [3:0]        s0_byteenable,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [31:0]       s0_writedata,
    output logic              s0_waitrequest,
    output logic [31:0]       s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic [3:0]        s1_byteenable,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [31:0]       s1_writedata,
    output logic              s1_waitrequest,
    output logic [31:0]       s1_readdata,
    output logic              s1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);
    logic req0, req1, gnt0, gnt1, wr_sel;
    logic rd_pend_q, rd_pend_d, rd_port_q, rd_port_d;
    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;
`ifdef ARQT_MEMARB_RR_EN
    typedef enum logic [1:0] {NONE, P0, P1} owner_t;
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    owner_t     owner_q, owner_d;
    logic [3:0] hold_q, hold_d;
    logic       last_q, last_d;
    logic       own_req, oth_req, keep, pick1;
    always_comb begin
        own_req = (owner_q == P0) ? req0 : (owner_q == P1) ? req1 : 1'b0;
        oth_req = (owner_q == P0) ? req1 : (owner_q == P1) ? req0 : 1'b0;
        keep    = own_req && (hold_q < HOLD_MAX || !oth_req);
        // pick1 selects port 1 as the candidate; the grant still needs its request
        pick1   = keep ? (owner_q == P1) :
                  (owner_q == P0) ? 1'b1 :
                  (owner_q == P1) ? 1'b0 :
                  (req0 && req1) ? !last_q : req1;
        gnt0    = reset_n & req0 & !pick1;
        gnt1    = reset_n & req1 & pick1;
        hold_d  = keep ? hold_q + {3'd0, hold_q < HOLD_MAX} : (gnt0 | gnt1) ? 4'd1 : 4'd0;
        owner_d = gnt0 ? P0 : gnt1 ? P1 : NONE;
        last_d  = (gnt0 | gnt1) ? gnt1 : last_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= NONE;
            hold_q  <= 4'd0;
            last_q  <= 1'b1;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end
`else
    assign gnt0 = reset_n & req0;
    assign gnt1 = reset_n & req1 & !req0;
`endif
    assign s0_waitrequest = !gnt0;
    assign s1_waitrequest = !gnt1;
    assign mem_address    = gnt1 ? s1_address    : s0_address;
    assign mem_byteenable = gnt1 ? s1_byteenable : s0_byteenable;
    assign mem_writedata  = gnt1 ? s1_writedata  : s0_writedata;
    assign wr_sel         = gnt1 ? s1_write      : s0_write;
    assign mem_chipselect = gnt0 | gnt1;
    assign mem_write      = mem_chipselect & wr_sel;
    assign mem_clken      = reset_n;
    always_comb begin
        rd_pend_d = mem_chipselect & !wr_sel;
        rd_port_d = gnt1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end
    assign s0_readdatavalid = rd_pend_q & !rd_port_q;
    assign s1_readdatavalid = rd_pend_q & rd_port_q;
    assign s0_readdata      = mem_readdata;
    assign s1_readdata      = mem_readdata;
endmodule

// File: tb/tb_arqt_mem_arbiter.sv
// tb_arqt_mem_arbiter: scoreboard bench for arqt_mem_arbiter with a 2048x32 RAM model.
// Runs the hold-limit scenario when ARQT_MEMARB_RR_EN is defined, fixed priority otherwise.
module tb_arqt_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] s0_address, s1_address, mem_address;
    logic [3:0]  s0_byteenable, s1_byteenable, mem_byteenable;
    logic        s0_read, s0_write, s1_read, s1_write;
    logic [31:0] s0_writedata, s1_writedata, s0_readdata, s1_readdata;
    logic        s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata, mem_rd_q;
    logic [31:0] mem [0:2047];
    logic [31:0] ref_mem [0:2047];

    typedef struct {logic port; logic [31:0] data;} sb_t;
    sb_t sb_q[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    arqt_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
        .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i]) mem[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            end else begin
                mem_rd_q <= mem[mem_address];
            end
        end
    end
    assign mem_readdata = mem_rd_q;

    task automatic set_p(input int p, input logic rd, input logic wr, input logic [10:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (p == 0) begin
            s0_read = rd; s0_write = wr; s0_address = a; s0_byteenable = be; s0_writedata = wd;
        end else begin
            s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = wd;
        end
    endtask

    task automatic idle();
        set_p(0, 0, 0, 11'd0, 4'd0, 32'd0);
        set_p(1, 0, 0, 11'd0, 4'd0, 32'd0);
    endtask

    task automatic apply(input logic p, input logic wr, input logic [10:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
        end else begin
            sb_q.push_back('{port: p, data: ref_mem[a]});
        end
    endtask

    // One bus cycle: check grants and read returns mid-cycle, then advance the model.
    task automatic step(input logic g0, input logic g1);
        sb_t  e;
        logic ev0, ev1;
        logic [31:0] got;
        @(negedge clk);
        total++;
        if (s0_waitrequest !== !g0 || s1_waitrequest !== !g1) begin
            bad++;
            $display("FAIL grant: waitrequest s0=%b s1=%b, required s0=%b s1=%b",
                     s0_waitrequest, s1_waitrequest, !g0, !g1);
        end
        total++;
        if (mem_chipselect !== (g0 | g1)) begin
            bad++;
            $display("FAIL chipselect: got %b, required %b", mem_chipselect, g0 | g1);
        end
        ev0 = 1'b0; ev1 = 1'b0; e = '{port: 1'b0, data: 32'd0};
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            ev0 = !e.port; ev1 = e.port;
        end
        total++;
        if ({s0_readdatavalid, s1_readdatavalid} !== {ev0, ev1}) begin
            bad++;
            $display("FAIL readdatavalid: got s0=%b s1=%b, required s0=%b s1=%b",
                     s0_readdatavalid, s1_readdatavalid, ev0, ev1);
        end else if (ev0 || ev1) begin
            got = ev0 ? s0_readdata : s1_readdata;
            total++;
            if (got !== e.data) begin
                bad++;
                $display("FAIL readdata port%0d: got %h, required %h", e.port, got, e.data);
            end
        end
        if (g0) apply(1'b0, s0_write, s0_address, s0_byteenable, s0_writedata);
        if (g1) apply(1'b1, s1_write, s1_address, s1_byteenable, s1_writedata);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid,
             mem_chipselect, mem_write, mem_clken} !== 7'b1100000) begin
            bad++;
            $display("FAIL %s: wr0 wr1 rdv0 rdv1 cs we clken = %b%b %b%b %b%b%b, required 11 00 000",
                     tag, s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid,
                     mem_chipselect, mem_write, mem_clken);
        end
    endtask

    task automatic test_reset();
        set_p(0, 1, 0, 11'h010, 4'hF, 32'd0);
        set_p(1, 1, 1, 11'h7FF, 4'hF, 32'd0);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        idle();
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (mem_clken !== 1'b1 || mem_chipselect !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: clken=%b cs=%b, required clken=1 cs=0", mem_clken, mem_chipselect);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        set_p(0, 0, 1, 11'h010, 4'hF, 32'hDEADBEEF);
        step(1, 0);
        idle();
        set_p(1, 1, 1, 11'h7FF, 4'hF, 32'h00000000);
        step(0, 1);
        idle();
        step(0, 0);
    endtask

    task automatic test_uncontended_read();
        set_p(0, 1, 0, 11'h010, 4'hF, 32'd0);
        step(1, 0);
        idle();
        step(0, 0);
    endtask

    task automatic test_first_contention();
        do_reset();
        set_p(0, 1, 0, 11'h010, 4'hF, 32'd0);
        set_p(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
        step(1, 0);
        set_p(0, 0, 0, 11'h000, 4'h0, 32'd0);
        step(0, 1);
        idle();
        step(0, 0);
    endtask

    task automatic test_byte_lane();
        set_p(1, 0, 1, 11'h7FF, 4'b0101, 32'hAABBCCDD);
        step(0, 1);
        set_p(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
        step(0, 1);
        idle();
        @(negedge clk);
        total++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h00BB00DD) begin
            bad++;
            $display("FAIL byte_lane: rdv=%b data=%h, required rdv=1 data=00bb00dd",
                     s1_readdatavalid, s1_readdata);
        end
        @(posedge clk); #1;
        sb_q.delete();
        step(0, 0);
    endtask

    task automatic test_back_to_back();
        logic [10:0] addrs [4];
        addrs[0] = 11'h010; addrs[1] = 11'h7FF; addrs[2] = 11'h7FF; addrs[3] = 11'h010;
        for (int i = 0; i < 4; i++) begin
            idle();
            set_p(i % 2, 1, 0, addrs[i], 4'hF, 32'd0);
            step(i % 2 == 0, i % 2 == 1);
        end
        idle();
        step(0, 0);
    endtask

`ifdef ARQT_MEMARB_RR_EN
    task automatic test_hold_limit();
        logic [15:0] pat;
        pat = 16'hF0F0;
        do_reset();
        set_p(0, 1, 0, 11'h010, 4'hF, 32'd0);
        set_p(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
        for (int i = 0; i < 16; i++) step(!pat[i], pat[i]);
        idle();
        step(0, 0);
    endtask
`else
    task automatic test_fixed_priority();
        do_reset();
        set_p(0, 1, 0, 11'h010, 4'hF, 32'd0);
        set_p(1, 0, 1, 11'h7FF, 4'hF, 32'h12345678);
        for (int i = 0; i < 8; i++) step(1, 0);
        idle();
        step(0, 0);
    endtask
`endif

    task automatic test_reset_mid_read();
        set_p(0, 1, 0, 11'h010, 4'hF, 32'd0);
        @(negedge clk);
        total++;
        if (s0_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL mid_read_accept: waitrequest=%b, required 0", s0_waitrequest);
        end
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_reset_outputs("reset_mid_read");
            @(posedge clk); #1;
        end
        idle();
        reset_n = 1'b1;
        sb_q.delete();
        step(0, 0);
        step(0, 0);
    endtask

    initial begin
        idle();
        test_reset();
        test_preload();
        test_uncontended_read();
        test_first_contention();
        test_byte_lane();
        test_back_to_back();
`ifdef ARQT_MEMARB_RR_EN
        test_hold_limit();
`else
        test_fixed_priority();
`endif
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
